hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed load-use hazard detector in the 5-stage core. It keeps a per-register countdown scoreboard of in-flight writers with configurable ALU and load latencies, so deeper data memories need no new hazard logic. It sits beside the ID stage and gates IF/ID/PC write enable and ID/EX bubble insertion. It also provides stall statistics and a stall watchdog.

Parameters:
REG_AW, 4, register address width; NREG = 2**REG_AW tracked registers
CNT_W, 3, scoreboard counter width; latencies must be <= 2**CNT_W-1
ALU_LAT, 1, cycles from issue until an ALU result is forwardable; range 1..2**CNT_W-1
LOAD_LAT, 2, cycles from issue until load data is forwardable; range ALU_LAT..2**CNT_W-1
STAT_W, 16, stall statistic counter width
MAX_STALL, 8, consecutive stall cycles before watchdog error; >=1

Ports:
clk  input  1  clock, all state on rising edge
rest  input  1  asynchronous active-low reset
id_valid  input  1  valid instruction in IF/ID
id_rs  input  REG_AW  source register 1
id_rt  input  REG_AW  source register 2
id_use_rs  input  1  instruction reads id_rs
id_use_rt  input  1  instruction reads id_rt
id_rd  input  REG_AW  destination register
id_wr  input  1  instruction writes id_rd
id_load  input  1  instruction is a load
flush  input  1  squash the IF/ID instruction this cycle
stall_o  output  1  hold PC and IF/ID; bubble into ID/EX
issue_o  output  1  instruction advances into ID/EX this cycle
busy_o  output  NREG  bit r set when cnt[r] != 0
stall_cnt_o  output  STAT_W  total stall cycles since reset, saturating
err_o  output  1  sticky watchdog error

Behaviour:
- Reset (rest low, asynchronous): every cnt[r]=0, stall_cnt_o=0, err_o=0, consecutive stall counter run=0. Therefore busy_o=0, stall_o=0, and issue_o=id_valid.
- Hazard, combinational: haz = (id_use_rs & cnt[id_rs]>=2) | (id_use_rt & cnt[id_rt]>=2). cnt==1 means the value is forwardable next cycle, so it does not stall.
- stall_o = id_valid & ~flush & haz. issue_o = id_valid & ~flush & ~haz. flush dominates stall.
- Scoreboard update, every edge, for each r:
  - If issue_o & id_wr & id_rd==r: cnt[r] <= id_load ? LOAD_LAT : ALU_LAT. A new issue overrides any remaining count because the younger writer wins (WAW).
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  - Else: cnt[r] holds at 0.
- Self-dependence (id_rd == id_rs with the hazard clear) is allowed. The check uses the pre-update count.
- A stalled or flushed instruction never writes the scoreboard.
- stall_cnt_o increments by 1 on each cycle with stall_o=1 and saturates at all-ones.
- Watchdog:
  - run <= stall_o ? run+1 : 0, saturating.
  - When stall_o=1 and run == MAX_STALL-1, err_o <= 1.
  - err_o clears only on reset. It does not block issue.
- Latency: a load issued at cycle t stalls a dependent in ID for exactly LOAD_LAT-1 cycles. A dependent on an ALU producer stalls ALU_LAT-1 cycles, which is 0 by default.
- Bounded stall: with constant inputs, a stall clears within LOAD_LAT-1 cycles. err_o therefore flags only misconfiguration or a broken external hold.

Test Plan:
- Reset: assert rest=0 mid-run with cnt[3]=2 -> busy_o=0, stall_cnt_o=0, err_o=0 immediately, no clock needed. With id_valid=1 after release, issue_o=1.
- Load-use (defaults): issue a load to r5 at t; at t+1 present a consumer with id_use_rs=1, id_rs=5 -> stall_o=1 at t+1, issue_o=1 at t+2, stall_cnt_o=1.
- ALU chain: an ALU writer to r2, then an immediate reader of r2 -> stall_o never asserts; busy_o[2] is 1 for exactly one cycle.
- WAW override: a load to r7 at t, an ALU write to r7 at t+1 under LOAD_LAT=4, ALU_LAT=1 -> load shows cnt 4 then ALU gives cnt[7]=1 at t+2 (visible as busy_o[7] dropping at t+3). A reader of r7 at t+2 issues without stall.
- Flush during hazard: a stalled consumer with flush=1 -> stall_o=0, issue_o=0, and the consumer's rd is not marked busy.
- Watchdog/saturation: LOAD_LAT=7, MAX_STALL=3, a dependent load-use -> 6 stall cycles; err_o rises after the third consecutive stall and stays 1. With STAT_W=2, stall_cnt_o sticks at 3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard of in-flight register writers for the ID stage: raises a stall
// on a read-after-write hazard, counts stall cycles, and flags stalls that never clear.
module hazard_scoreboard #(
    parameter int REG_AW    = 4,
    parameter int CNT_W     = 3,
    parameter int ALU_LAT   = 1,
    parameter int LOAD_LAT  = 2,
    parameter int STAT_W    = 16,
    parameter int MAX_STALL = 8
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_wr,
    input  logic                   id_load,
    input  logic                   flush,
    output logic                   stall_o,
    output logic                   issue_o,
    output logic [2**REG_AW-1:0]   busy_o,
    output logic [STAT_W-1:0]      stall_cnt_o,
    output logic                   err_o
);

    localparam int NREG  = 2**REG_AW;
    localparam int RUN_W = $clog2(MAX_STALL + 1);

    localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(MAX_STALL - 1);

    logic [CNT_W-1:0] cnt [NREG];
    logic [RUN_W-1:0] run;
    logic             haz;

    // A count of 1 means the value reaches the bypass network next cycle, so only >=2 stalls.
    always_comb begin
        haz = 1'b0;
        if (id_use_rs && (cnt[id_rs] > CNT_W'(1)))
            haz = 1'b1;
        if (id_use_rt && (cnt[id_rt] > CNT_W'(1)))
            haz = 1'b1;
    end

    assign stall_o = id_valid & ~flush & haz;
    assign issue_o = id_valid & ~flush & ~haz;

    always_comb begin
        busy_o = '0;
        for (int r = 0; r < NREG; r++)
            busy_o[r] = (cnt[r] != '0);
    end

    // The youngest issuing writer reloads its destination count, discarding any older writer.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (issue_o && id_wr && (id_rd == REG_AW'(r)))
                    cnt[r] <= id_load ? LOAD_CNT : ALU_CNT;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            stall_cnt_o <= '0;
            run         <= '0;
            err_o       <= 1'b0;
        end else begin
            if (stall_o && (stall_cnt_o != {STAT_W{1'b1}}))
                stall_cnt_o <= stall_cnt_o + STAT_W'(1);
            if (!stall_o)
                run <= '0;
            else if (run != RUN_MAX)
                run <= run + RUN_W'(1);
            if (stall_o && (run == RUN_TRIP))
                err_o <= 1'b1;
        end
    end

endmodule
